// File: rtl/alu_shift_seq_pkg.sv
// Shared definitions for the iterative shifter: mode encoding, FSM state
// type and default datapath widths.
package alu_shift_pkg;

    localparam int DATA_W = 16;
    localparam int AMT_W  = 4;

    localparam logic [1:0] SHIFT_SLL  = 2'b00;
    localparam logic [1:0] SHIFT_SRA  = 2'b01;
    localparam logic [1:0] SHIFT_ROR  = 2'b10;
    localparam logic [1:0] SHIFT_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/alu_shift_seq_shift_step.sv
// One-position shift step. SLL reports whether this step changes the sign
// bit (the top two bits differ before shifting). Reserved mode passes
// the value through unchanged.
module shift_step
    import alu_shift_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] value,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] next_value,
    output logic             ovfl_bit
);

    // Single-position SLL / SRA / ROR with pass-through default
    always_comb begin
        next_value = value;
        ovfl_bit   = 1'b0;
        case (mode)
            SHIFT_SLL: begin
                next_value = {value[WIDTH-2:0], 1'b0};
                ovfl_bit   = value[WIDTH-1] ^ value[WIDTH-2];
            end
            SHIFT_SRA: next_value = {value[WIDTH-1], value[WIDTH-1:1]};
            SHIFT_ROR: next_value = {value[0], value[WIDTH-1:1]};
            default:   next_value = value;
        endcase
    end

endmodule

// File: rtl/alu_shift_seq.sv
// Iterative SLL/SRA/ROR shifter with valid/ready on both sides.
// Optional build macro ALU_SHIFT_SEQ_DUAL_STEP_EN chains two shift steps
// so two positions are consumed per edge while at least two remain.
// Results and flags are identical either way; only latency changes.
//
// state | meaning
// IDLE  | ready to accept a request
// SHIFT | shifting the work register, counter tracks positions left
// DONE  | result and flags valid, waiting for out_ready
module alu_shift_seq
    import alu_shift_pkg::*;
#(
    parameter int WIDTH   = DATA_W,
    parameter int SHAMT_W = AMT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] b,
    input  logic [1:0]         mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               sign,
    output logic               ovfl
);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] cnt;
    logic [SHAMT_W-1:0] cnt_dec;
    logic [1:0]         mode_q;
    logic               ovfl_acc;
    logic               accept;
    logic               last_step;
    logic [WIDTH-1:0]   step1;
    logic [WIDTH-1:0]   step_out;
    logic               ovfl1;
    logic               step_ovfl;

    assign accept = in_valid && (state == IDLE);

    shift_step #(.WIDTH(WIDTH)) u_step0 (
        .value      (work),
        .mode       (mode_q),
        .next_value (step1),
        .ovfl_bit   (ovfl1)
    );

`ifdef ALU_SHIFT_SEQ_DUAL_STEP_EN
    logic [WIDTH-1:0] step2;
    logic             ovfl2;
    logic             two;

    shift_step #(.WIDTH(WIDTH)) u_step1 (
        .value      (step1),
        .mode       (mode_q),
        .next_value (step2),
        .ovfl_bit   (ovfl2)
    );

    // Second step's overflow is only meaningful when it is actually taken
    assign two       = (cnt >= SHAMT_W'(2));
    assign step_out  = two ? step2 : step1;
    assign step_ovfl = ovfl1 | (two & ovfl2);
    assign cnt_dec   = two ? SHAMT_W'(2) : SHAMT_W'(1);
    assign last_step = (cnt <= SHAMT_W'(2));
`else
    assign step_out  = step1;
    assign step_ovfl = ovfl1;
    assign cnt_dec   = SHAMT_W'(1);
    assign last_step = (cnt == SHAMT_W'(1));
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if ((b == '0) || (mode == SHIFT_RSVD)) state_nxt = DONE;
                    else                                   state_nxt = SHIFT;
                end
            end
            SHIFT:   if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Work register, position counter, captured mode and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work     <= '0;
            cnt      <= '0;
            mode_q   <= SHIFT_SLL;
            ovfl_acc <= 1'b0;
        end else if (accept) begin
            work     <= a;
            cnt      <= b;
            mode_q   <= mode;
            ovfl_acc <= 1'b0;
        end else if (state == SHIFT) begin
            work     <= step_out;
            cnt      <= cnt - cnt_dec;
            ovfl_acc <= ovfl_acc | step_ovfl;
        end
    end

    // Outputs are forced to zero outside DONE so reset/idle flags read 0
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        result    = out_valid ? work : '0;
        zero      = out_valid && (work == '0);
        sign      = out_valid && work[WIDTH-1];
        ovfl      = out_valid && ovfl_acc && (mode_q == SHIFT_SLL);
    end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Directed and random checks for alu_shift_seq; latency expectations
// follow ALU_SHIFT_SEQ_DUAL_STEP_EN when it is defined.
module tb_alu_shift_seq;

`ifdef ALU_SHIFT_SEQ_DUAL_STEP_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [3:0]  b = '0;
    logic [1:0]  mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic        zero, sign, ovfl;

    int checks = 0;
    int errors = 0;

    alu_shift_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .sign      (sign),
        .ovfl      (ovfl)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int exp_lat(input logic [3:0] bi, input logic [1:0] mi);
        if (mi == 2'b11 || bi == 4'd0) return 0;
        return DUAL ? (int'(bi) + 1) / 2 : int'(bi);
    endfunction

    // Accept a request, then scramble the inputs and wait (bounded) for out_valid.
    task automatic send_req(input logic [15:0] ai, input logic [3:0] bi,
                            input logic [1:0] mi, output int lat);
        @(negedge clk);
        a = ai; b = bi; mode = mi; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~ai; b = ~bi; mode = ~mi;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handoff();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, result, zero, sign, ovfl} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b res=%h z=%b s=%b o=%b want rdy=1 vld=0 res=0000 flags=000",
                     in_ready, out_valid, result, zero, sign, ovfl);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sll();
        int lat;
        send_req(16'h1234, 4'd3, 2'b00, lat);
        checks++;
        if (lat !== (DUAL ? 2 : 3)) begin
            errors++; $display("FAIL sll_latency: got %0d want %0d", lat, DUAL ? 2 : 3);
        end
        checks++;
        if ({result, zero, sign, ovfl} !== {16'h91A0, 1'b0, 1'b1, 1'b1}) begin
            errors++; $display("FAIL sll_result: got %h z%b s%b o%b want 91a0 z0 s1 o1", result, zero, sign, ovfl);
        end
        handoff();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL sll_handoff: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_sra_ror();
        int lat;
        send_req(16'hEDCC, 4'd3, 2'b01, lat);
        checks++;
        if (lat !== (DUAL ? 2 : 3)) begin
            errors++; $display("FAIL sra_latency: got %0d want %0d", lat, DUAL ? 2 : 3);
        end
        checks++;
        if ({result, zero, sign, ovfl} !== {16'hFDB9, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL sra_result: got %h z%b s%b o%b want fdb9 z0 s1 o0", result, zero, sign, ovfl);
        end
        handoff();
        send_req(16'hF000, 4'd4, 2'b10, lat);
        checks++;
        if (lat !== (DUAL ? 2 : 4)) begin
            errors++; $display("FAIL ror_latency: got %0d want %0d", lat, DUAL ? 2 : 4);
        end
        checks++;
        if ({result, zero, sign, ovfl} !== {16'h0F00, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL ror_result: got %h z%b s%b o%b want 0f00 z0 s0 o0", result, zero, sign, ovfl);
        end
        handoff();
    endtask

    task automatic test_edge();
        int lat;
        send_req(16'h8000, 4'd1, 2'b00, lat);
        checks++;
        if (lat !== 1) begin
            errors++; $display("FAIL sll1_latency: got %0d want 1", lat);
        end
        checks++;
        if ({result, zero, sign, ovfl} !== {16'h0000, 1'b1, 1'b0, 1'b1}) begin
            errors++; $display("FAIL sll1_result: got %h z%b s%b o%b want 0000 z1 s0 o1", result, zero, sign, ovfl);
        end
        handoff();
        send_req(16'h5A5A, 4'd0, 2'b11, lat);
        checks++;
        if (lat !== 0) begin
            errors++; $display("FAIL rsvd_latency: got %0d want 0", lat);
        end
        checks++;
        if ({result, zero, sign, ovfl} !== {16'h5A5A, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL rsvd_result: got %h z%b s%b o%b want 5a5a z0 s0 o0", result, zero, sign, ovfl);
        end
        handoff();
        send_req(16'hC3C3, 4'd7, 2'b11, lat);
        checks++;
        if (lat !== 0 || result !== 16'hC3C3) begin
            errors++; $display("FAIL rsvd_b7: got lat=%0d res=%h want lat=0 res=c3c3", lat, result);
        end
        handoff();
    endtask

    task automatic test_backpressure();
        int lat;
        send_req(16'h0003, 4'd2, 2'b00, lat);
        checks++;
        if (result !== 16'h000C || ovfl !== 1'b0) begin
            errors++; $display("FAIL bp_result: got %h o%b want 000c o0", result, ovfl);
        end
        @(negedge clk);
        in_valid = 1'b1; a = 16'hFFFF; b = 4'd1; mode = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, result, zero, sign, ovfl} !== {1'b1, 1'b0, 16'h000C, 3'b000}) begin
                errors++;
                $display("FAIL bp_hold%0d: got vld=%b rdy=%b res=%h flags=%b%b%b want vld=1 rdy=0 res=000c flags=000",
                         i, out_valid, in_ready, result, zero, sign, ovfl);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        handoff();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL bp_release: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        a = 16'h0001; b = 4'd15; mode = 2'b00; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, result, zero, sign, ovfl} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
            errors++;
            $display("FAIL reset_mid: got rdy=%b vld=%b res=%h flags=%b%b%b want rdy=1 vld=0 res=0000 flags=000",
                     in_ready, out_valid, result, zero, sign, ovfl);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_ready: got %b want 1", in_ready);
        end
        send_req(16'h1234, 4'd8, 2'b10, lat);
        checks++;
        if (lat !== (DUAL ? 4 : 8) || result !== 16'h3412 || {zero, sign, ovfl} !== 3'b000) begin
            errors++; $display("FAIL reset_mid_after: got lat=%0d res=%h flags=%b%b%b want lat=%0d res=3412 flags=000",
                               lat, result, zero, sign, ovfl, DUAL ? 4 : 8);
        end
        handoff();
    endtask

    task automatic test_back_to_back();
        int lat;
        int done_cnt = 0;
        logic [15:0] ai, exp_res;
        logic [3:0]  bi;
        logic [1:0]  mi;
        logic        exp_ovfl;
        logic [31:0] dbl;
        logic signed [15:0] sa, sh;
        for (int n = 0; n < 20; n++) begin
            ai = 16'($urandom);
            bi = 4'($urandom_range(0, 15));
            mi = 2'($urandom_range(0, 3));
            sa = ai;
            sh = ai << bi;
            dbl = {ai, ai} >> bi;
            exp_ovfl = 1'b0;
            case (mi)
                2'b00: begin exp_res = ai << bi; exp_ovfl = ((sh >>> bi) != sa); end
                2'b01: exp_res = sa >>> bi;
                2'b10: exp_res = dbl[15:0];
                default: exp_res = ai;
            endcase
            send_req(ai, bi, mi, lat);
            if (out_valid === 1'b1) done_cnt++;
            checks++;
            if (lat !== exp_lat(bi, mi) || result !== exp_res || zero !== (exp_res == 16'h0) ||
                sign !== exp_res[15] || ovfl !== exp_ovfl) begin
                errors++;
                $display("FAIL b2b_%0d a=%h b=%0d m=%0d: got lat=%0d res=%h z%b s%b o%b want lat=%0d res=%h z%b s%b o%b",
                         n, ai, bi, mi, lat, result, zero, sign, ovfl, exp_lat(bi, mi), exp_res,
                         exp_res == 16'h0, exp_res[15], exp_ovfl);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            handoff();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL b2b_dup_%0d: got vld=%b want 0", n, out_valid);
            end
        end
        checks++;
        if (done_cnt !== 20) begin
            errors++; $display("FAIL b2b_count: got %0d want 20", done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_sll();
        test_sra_ror();
        test_edge();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
